// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 control unit: ALU opcodes, instruction
// classes, controller states and immediate-extension rules.
package cr16_pkg;

   // ALU opcodes as seen on the datapath opcode input (shared with alu)
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDC = 4'd1,
      OP_MUL  = 4'd2,
      OP_SUB  = 4'd3,
      OP_SUBC = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_NOT  = 4'd8,
      OP_LSH  = 4'd9,
      OP_RSH  = 4'd10,
      OP_ARSH = 4'd11
   } alu_op_t;

   // Instruction classes in IR[15:12]; 1..12 are the I-type ALU classes
   localparam logic [3:0] CLS_RTYPE = 4'h0;
   localparam logic [3:0] CLS_LOAD  = 4'hD;
   localparam logic [3:0] CLS_NOP   = 4'hE;
   localparam logic [3:0] CLS_HALT  = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_LOADW,
      ST_HALT
   } state_t;

   // Arithmetic opcodes take a signed immediate; logic and shift ops do not
   function automatic logic sign_extend_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_MUL) || (op == OP_SUB);
   endfunction

   // Register index to write-strobe one-hot
   function automatic logic [15:0] reg_one_hot(input logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the instruction register into datapath controls
// and class flags used by the controller FSM.
module instruction_decoder
   import cr16_pkg::*;
(
   input  logic [15:0] ir,
   output logic [3:0]  reg_a_select,
   output logic [3:0]  reg_b_select,
   output logic [3:0]  opcode,
   output logic [15:0] immediate,
   output logic        immediate_select,
   output logic        is_alu,
   output logic        is_load,
   output logic        is_halt
);

   logic [3:0] cls;
   assign cls = ir[15:12];

   // Field extraction per instruction class
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      reg_a_select     = ir[11:8];
      reg_b_select     = 4'd0;
      opcode           = 4'd0;
      immediate        = 16'h0000;
      immediate_select = 1'b0;
      is_alu           = 1'b0;
      is_load          = 1'b0;
      is_halt          = 1'b0;
      case (cls)
         CLS_RTYPE: begin
            reg_b_select = ir[3:0];
            opcode       = ir[7:4];
            // Opcode fields past ARSH have no ALU meaning and behave as NOP
            is_alu       = (ir[7:4] <= OP_ARSH);
         end
         CLS_LOAD: begin
            reg_b_select = ir[3:0];
            is_load      = 1'b1;
         end
         CLS_NOP: begin
         end
         CLS_HALT: begin
            is_halt = 1'b1;
         end
         default: begin
            opcode           = cls - 4'd1;
            immediate_select = 1'b1;
            is_alu           = 1'b1;
            immediate        = sign_extend_op(cls - 4'd1) ? {{8{ir[7]}}, ir[7:0]}
                                                          : {8'h00, ir[7:0]};
         end
      endcase
   end

endmodule

// File: rtl/controller.sv
// Multi-cycle CR16 control unit: fetches over a shared read port, decodes,
// and drives every datapath control input. Holds the FSM, PC and IR.
module controller
   import cr16_pkg::*;
#(
   parameter logic [15:0] P_PC_RESET = 16'h0000
) (
   input  logic        I_CLK,
   input  logic        I_NRESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_MEM_DATA,
   input  logic        I_MEM_VALID,
   input  logic [15:0] I_B,
   output logic        O_MEM_REQ,
   output logic [15:0] O_MEM_ADDR,
   output logic [15:0] O_PC,
   output logic [15:0] O_REG_WRITE_ENABLE,
   output logic [3:0]  O_REG_A_SELECT,
   output logic [3:0]  O_REG_B_SELECT,
   output logic [15:0] O_IMMEDIATE,
   output logic        O_IMMEDIATE_SELECT,
   output logic [3:0]  O_OPCODE,
   output logic        O_REGFILE_DATA_SELECT,
   output logic        O_HALTED
);

   state_t      state, state_next;
   logic [15:0] pc, pc_next;
   logic [15:0] ir, ir_next;

   logic [3:0]  dec_a_sel, dec_b_sel, dec_opcode;
   logic [15:0] dec_imm;
   logic        dec_imm_sel, dec_is_alu, dec_is_load, dec_is_halt;

   instruction_decoder u_decoder (
      .ir               (ir),
      .reg_a_select     (dec_a_sel),
      .reg_b_select     (dec_b_sel),
      .opcode           (dec_opcode),
      .immediate        (dec_imm),
      .immediate_select (dec_imm_sel),
      .is_alu           (dec_is_alu),
      .is_load          (dec_is_load),
      .is_halt          (dec_is_halt)
   );

   assign O_PC = pc;

   // State, PC and IR registers
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state <= ST_FETCH;
         pc    <= P_PC_RESET;
         ir    <= 16'h0000;
      end else begin
         // NOTE: non-blocking so all three registers update from the same pre-edge values.
         state <= state_next;
         pc    <= pc_next;
         ir    <= ir_next;
      end
   end

   // Next-state logic and control outputs; I_ENABLE low freezes everything
   always_comb begin
      state_next            = state;
      pc_next               = pc;
      ir_next               = ir;
      O_MEM_REQ             = 1'b0;
      O_MEM_ADDR            = pc;
      O_REG_WRITE_ENABLE    = 16'h0000;
      O_REG_A_SELECT        = 4'd0;
      O_REG_B_SELECT        = 4'd0;
      O_IMMEDIATE           = 16'h0000;
      O_IMMEDIATE_SELECT    = 1'b0;
      O_OPCODE              = 4'd0;
      O_REGFILE_DATA_SELECT = 1'b0;
      O_HALTED              = 1'b0;

      // Decoded controls are presented only from DECODE through the strobe
      if (state == ST_DECODE || state == ST_EXEC || state == ST_LOADW) begin
         O_REG_A_SELECT     = dec_a_sel;
         O_REG_B_SELECT     = dec_b_sel;
         O_IMMEDIATE        = dec_imm;
         O_IMMEDIATE_SELECT = dec_imm_sel;
         O_OPCODE           = dec_opcode;
      end

      case (state)
         ST_FETCH: begin
            O_MEM_REQ = I_ENABLE;
            if (I_ENABLE && I_MEM_VALID) begin
               ir_next    = I_MEM_DATA;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (I_ENABLE) begin
               if (dec_is_load)      state_next = ST_LOADW;
               else if (dec_is_halt) state_next = ST_HALT;
               else                  state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (I_ENABLE) begin
               if (dec_is_alu) O_REG_WRITE_ENABLE = reg_one_hot(dec_a_sel);
               pc_next    = pc + 16'd1;
               state_next = ST_FETCH;
            end
         end
         ST_LOADW: begin
            O_MEM_ADDR = I_B;
            O_MEM_REQ  = I_ENABLE;
            if (I_ENABLE && I_MEM_VALID) begin
               O_REGFILE_DATA_SELECT = 1'b1;
               O_REG_WRITE_ENABLE    = reg_one_hot(dec_a_sel);
               pc_next               = pc + 16'd1;
               state_next            = ST_FETCH;
            end
         end
         ST_HALT: begin
            O_HALTED = 1'b1;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: behavioural memory and register-file stand-in,
// table of single instructions, hand sequences for wait, stall, halt, reset.
module tb_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, enable, force_valid;
   logic [15:0] mem_data, b_bus, mem_addr, pc, we, imm;
   logic        mem_valid, mem_req, imm_sel, rds, halted;
   logic [3:0]  a_sel, b_sel, opcode;

   logic [15:0] w_addr, w_pc, w_we, w_imm;
   logic        w_req, w_imm_sel, w_rds, w_halted;
   logic [3:0]  w_a_sel, w_b_sel, w_opcode;

   controller #(.P_PC_RESET(16'h0000)) dut (
      .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(enable),
      .I_MEM_DATA(mem_data), .I_MEM_VALID(mem_valid), .I_B(b_bus),
      .O_MEM_REQ(mem_req), .O_MEM_ADDR(mem_addr), .O_PC(pc),
      .O_REG_WRITE_ENABLE(we), .O_REG_A_SELECT(a_sel), .O_REG_B_SELECT(b_sel),
      .O_IMMEDIATE(imm), .O_IMMEDIATE_SELECT(imm_sel), .O_OPCODE(opcode),
      .O_REGFILE_DATA_SELECT(rds), .O_HALTED(halted)
   );

   // Second instance starting at FFFF, fed an endless stream of NOPs
   controller #(.P_PC_RESET(16'hFFFF)) dut_wrap (
      .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(1'b1),
      .I_MEM_DATA(16'hE000), .I_MEM_VALID(w_req), .I_B(16'h0000),
      .O_MEM_REQ(w_req), .O_MEM_ADDR(w_addr), .O_PC(w_pc),
      .O_REG_WRITE_ENABLE(w_we), .O_REG_A_SELECT(w_a_sel), .O_REG_B_SELECT(w_b_sel),
      .O_IMMEDIATE(w_imm), .O_IMMEDIATE_SELECT(w_imm_sel), .O_OPCODE(w_opcode),
      .O_REGFILE_DATA_SELECT(w_rds), .O_HALTED(w_halted)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Memory model: programmable wait states, optional spurious valid
   logic [15:0] mem [256];
   int unsigned mem_wait;
   int unsigned wait_cnt = 0;
   assign mem_valid = (mem_req && (wait_cnt >= mem_wait)) || force_valid;
   assign mem_data  = mem[mem_addr[7:0]];
   always @(posedge clk) wait_cnt <= (!mem_req || mem_valid) ? 0 : wait_cnt + 1;

   // Register-file / ALU stand-in for the datapath
   logic [15:0] regs [16] = '{default: 16'h0000};
   assign b_bus = regs[b_sel];

   function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0:    return a + b;
         4'd2:    return 16'(a * b);
         4'd3:    return a - b;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return a ^ b;
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (we != 16'h0000)
         for (int i = 0; i < 16; i++)
            if (we[i]) regs[i] <= rds ? mem_data : alu_model(opcode, regs[a_sel], imm_sel ? imm : regs[b_sel]);
   end

   // Scoreboard of expected write strobes
   typedef struct {
      logic [15:0] we;
      logic        rds;
      logic [3:0]  opcode;
      logic [15:0] imm;
      logic        imm_sel;
      logic [3:0]  a_sel;
      logic [3:0]  b_sel;
   } exp_t;
   exp_t sb [$];

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && we != 16'h0000) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", we, 16'h0000);
         end else begin
            e = sb.pop_front();
            check("strobe_we", we, e.we);
            check("strobe_rds", rds, e.rds);
            check("strobe_opcode", opcode, e.opcode);
            check("strobe_imm", imm, e.imm);
            check("strobe_imm_sel", imm_sel, e.imm_sel);
            check("strobe_a_sel", a_sel, e.a_sel);
            check("strobe_b_sel", b_sel, e.b_sel);
         end
      end else if (rst_n && rds) begin
         check("rds_without_strobe", rds, 1'b0);
      end
   end

   typedef struct {
      string       name;
      logic [15:0] instr;
      int          wait_cycles;
      logic [15:0] we;
      logic        rds;
      logic [3:0]  opcode;
      logic [15:0] imm;
      logic        imm_sel;
      logic [3:0]  a_sel;
      logic [3:0]  b_sel;
      int          ridx;
      logic [15:0] rval;
   } vec_t;
   vec_t vecs [10];

   logic [15:0] exp_pc;

   // Places one instruction at the expected PC and runs until PC moves on
   task automatic run_instr(input logic [15:0] instr, input int w, output int addr40, output int rds_n);
      logic [15:0] start;
      start    = exp_pc;
      mem[start[7:0]] = instr;
      mem_wait = w;
      addr40   = 0;
      rds_n    = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h0040) addr40++;
         if (rds) rds_n++;
         if (pc != start) break;
      end
      exp_pc = start + 16'd1;
      check("pc_advance", pc, exp_pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a40, rn;
      rst_n = 1'b0; enable = 1'b1; force_valid = 1'b0; mem_wait = 0; exp_pc = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
      mem[0]     = 16'h1105;
      mem[1]     = 16'h0201;
      mem[8'h40] = 16'hBEEF;

      vecs[0] = '{"subi_sext",  16'h41FF, 0, 16'h0002, 1'b0, 4'd3, 16'hFFFF, 1'b1, 4'd1, 4'd0, 1, 16'h0006};
      vecs[1] = '{"andi_zext",  16'h61FF, 1, 16'h0002, 1'b0, 4'd5, 16'h00FF, 1'b1, 4'd1, 4'd0, 1, 16'h0006};
      vecs[2] = '{"addi_r4",    16'h1440, 0, 16'h0010, 1'b0, 4'd0, 16'h0040, 1'b1, 4'd4, 4'd0, 4, 16'h0040};
      vecs[3] = '{"or_rtype",   16'h0362, 0, 16'h0008, 1'b0, 4'd6, 16'h0000, 1'b0, 4'd3, 4'd2, 3, 16'h0005};
      vecs[4] = '{"rtype_nop",  16'h02C1, 0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 2, 16'h0005};
      vecs[5] = '{"nop_wait",   16'hE123, 2, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 1, 16'h0006};
      vecs[6] = '{"addi_neg",   16'h1580, 0, 16'h0020, 1'b0, 4'd0, 16'hFF80, 1'b1, 4'd5, 4'd0, 5, 16'hFF80};
      vecs[7] = '{"xori_zext",  16'h8580, 0, 16'h0020, 1'b0, 4'd7, 16'h0080, 1'b1, 4'd5, 4'd0, 5, 16'hFF00};
      vecs[8] = '{"load_r8",    16'hD804, 0, 16'h0100, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd8, 4'd4, 8, 16'hBEEF};
      vecs[9] = '{"muli_sext",  16'h35FE, 0, 16'h0020, 1'b0, 4'd2, 16'hFFFE, 1'b1, 4'd5, 4'd0, 5, 16'h0200};

      // ADDI R1,5 then ADD R2,R1 straight out of reset
      sb.push_back('{16'h0002, 1'b0, 4'd0, 16'h0005, 1'b1, 4'd1, 4'd0});
      sb.push_back('{16'h0004, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 4'd1});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_pc", pc, 16'h0000);
      check("rst_we", we, 16'h0000);
      check("rst_a_sel", a_sel, 4'd0);
      check("rst_b_sel", b_sel, 4'd0);
      check("rst_imm", imm, 16'h0000);
      check("rst_imm_sel", imm_sel, 1'b0);
      check("rst_opcode", opcode, 4'd0);
      check("rst_rds", rds, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_req", mem_req, 1'b1);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_wrap_pc", w_pc, 16'hFFFF);
      repeat (3) @(negedge clk);
      check("wrap_pc", w_pc, 16'h0000);
      check("pc_after_3", pc, 16'h0001);
      repeat (3) @(negedge clk);
      check("pc_after_6", pc, 16'h0002);
      check("addi_r1", regs[1], 16'h0005);
      check("add_r2", regs[2], 16'h0005);
      exp_pc = 16'h0002;

      // NOP at PC 2, HALT at PC 3 with spurious valids while halted
      run_instr(16'hE000, 0, a40, rn);
      mem[3] = 16'hF000;
      for (int c = 0; c < 20 && !halted; c++) @(negedge clk);
      check("halted", halted, 1'b1);
      force_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("halt_req", mem_req, 1'b0);
         check("halt_pc", pc, 16'h0003);
      end
      force_valid = 1'b0;

      // Reset leaves HALT
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst2_halted", halted, 1'b0);
      check("rst2_pc", pc, 16'h0000);
      check("rst2_req", mem_req, 1'b1);
      exp_pc = 16'h0000;

      // Table of single instructions
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we != 16'h0000)
            sb.push_back('{vecs[i].we, vecs[i].rds, vecs[i].opcode, vecs[i].imm,
                           vecs[i].imm_sel, vecs[i].a_sel, vecs[i].b_sel});
         run_instr(vecs[i].instr, vecs[i].wait_cycles, a40, rn);
         check({vecs[i].name, "_reg"}, regs[vecs[i].ridx], vecs[i].rval);
      end

      // LOAD R3,[R4] with two wait states
      sb.push_back('{16'h0008, 1'b1, 4'd0, 16'h0000, 1'b0, 4'd3, 4'd4});
      run_instr(16'hD304, 2, a40, rn);
      check("load_addr_cycles", a40, 3);
      check("load_rds_pulses", rn, 1);
      check("load_r3", regs[3], 16'hBEEF);

      // ADDI R6,5 stalled for four cycles in EXEC
      mem[exp_pc[7:0]] = 16'h1605;
      mem_wait = 0;
      sb.push_back('{16'h0040, 1'b0, 4'd0, 16'h0005, 1'b1, 4'd6, 4'd0});
      @(posedge clk);
      @(posedge clk);
      #1 enable = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("stall_we", we, 16'h0000);
         check("stall_pc", pc, exp_pc);
      end
      @(posedge clk);
      #1 enable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (pc != exp_pc) break;
      end
      exp_pc = exp_pc + 16'd1;
      check("stall_pc_advance", pc, exp_pc);
      check("stall_r6", regs[6], 16'h0005);

      // Reset while LOADW waits for data
      mem[exp_pc[7:0]] = 16'hD704;
      mem_wait = 5;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 16'h0040) break;
      end
      check("loadw_reached", mem_addr, 16'h0040);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_we", we, 16'h0000);
      mem_wait = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst3_pc", pc, 16'h0000);
      check("rst3_addr", mem_addr, 16'h0000);
      check("rst3_req", mem_req, 1'b1);
      check("rst3_r7", regs[7], 16'h0000);
      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
